// File: rtl/d5m_pgen_pkg.sv
// Shared types and constants for the D5M synthetic pattern source.
// The state and mode encodings, bar colour table and LFSR constants live here.
package d5m_pgen_pkg;

   localparam int COORD_W = 16;
   localparam int PIX_W   = 12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HBLK   = 2'd1,
      ACTIVE = 2'd2,
      VBLK   = 2'd3
   } pgen_state_e;

   typedef enum logic [1:0] {
      MODE_BARS    = 2'd0,
      MODE_RAMP    = 2'd1,
      MODE_CHECKER = 2'd2,
      MODE_FRAME   = 2'd3
   } pgen_mode_e;

   // {R,G,B} per bar; index 0 is the leftmost bar (white) through 7 (black)
   localparam logic [7:0][2:0] BAR_RGB = {
      3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
   };

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/d5m_pgen_pixel.sv
// Combinational pixel generator: (x, y, mode, frame number) -> 12-bit Bayer value.
module d5m_pgen_pixel
   import d5m_pgen_pkg::*;
#(
   parameter int H_ACTIVE = 640
) (
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  pgen_mode_e         mode,
   input  logic [PIX_W-1:0]   frame_num,
   output logic [PIX_W-1:0]   pix
);

   localparam int BAR_W = H_ACTIVE / 8;

   logic [COORD_W-1:0] bar_div;
   logic [2:0]         bar_idx;
   logic [2:0]         rgb;
   logic               chan;

   always_comb begin
      bar_div = x / COORD_W'(BAR_W);
      // remainder pixels past the eighth bar stay black
      bar_idx = (bar_div > COORD_W'(7)) ? 3'd7 : bar_div[2:0];
      rgb     = BAR_RGB[bar_idx];

      case ({y[0], x[0]})
         2'b01:   chan = rgb[2];
         2'b10:   chan = rgb[0];
         default: chan = rgb[1];
      endcase

      case (mode)
         MODE_BARS:    pix = {PIX_W{chan}};
         MODE_RAMP:    pix = {x[9:0], 2'b00};
         MODE_CHECKER: pix = {PIX_W{x[5] ^ y[5]}};
         MODE_FRAME:   pix = frame_num;
         default:      pix = '0;
      endcase
   end

endmodule

// File: rtl/d5m_pattern_gen.sv
// Synthetic D5M sensor source: FVAL/LVAL framing with deterministic Bayer test patterns.
// Define D5M_PGEN_NOISE_EN to XOR a 16-bit LFSR into the two LSBs of active pixels.
module d5m_pattern_gen
   import d5m_pgen_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int H_BLANK  = 16,
   parameter int V_BLANK  = 64
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        iSTART,
   input  logic        iSTOP,
   input  logic [1:0]  iMODE,
   output logic [11:0] oDATA,
   output logic        oFVAL,
   output logic        oLVAL,
   output logic [31:0] oFrame_Cont,
   output logic        oBUSY
);

   localparam int XW   = $clog2(H_ACTIVE);
   localparam int YW   = $clog2(V_ACTIVE);
   localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
   localparam int BW   = $clog2(BMAX + 1);

   pgen_state_e       state_q, state_n;
   logic [XW-1:0]     x_q, x_n;
   logic [YW-1:0]     y_q, y_n;
   logic [BW-1:0]     b_q, b_n;
   logic              stop_q, stop_n;
   pgen_mode_e        mode_q, mode_n;
   logic [PIX_W-1:0]  fnum_q, fnum_n;
   logic [31:0]       frame_cnt_q;
   logic              cnt_inc;

   logic [PIX_W-1:0]  pix_n;
   logic [PIX_W-1:0]  noise;
   logic [PIX_W-1:0]  data_q;
   logic              fval_q, lval_q, busy_q;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         b_q     <= '0;
         stop_q  <= 1'b0;
         mode_q  <= MODE_BARS;
         fnum_q  <= '0;
      end else begin
         state_q <= state_n;
         x_q     <= x_n;
         y_q     <= y_n;
         b_q     <= b_n;
         stop_q  <= stop_n;
         mode_q  <= mode_n;
         fnum_q  <= fnum_n;
      end
   end

   always_comb begin
      state_n = state_q;
      x_n     = x_q;
      y_n     = y_q;
      b_n     = b_q;
      mode_n  = mode_q;
      fnum_n  = fnum_q;
      cnt_inc = 1'b0;
      stop_n  = stop_q | ((state_q != IDLE) & iSTOP);

      case (state_q)
         IDLE: begin
            stop_n = 1'b0;
            if (iSTART && !iSTOP) begin
               state_n = HBLK;
               x_n     = '0;
               y_n     = '0;
               b_n     = '0;
               mode_n  = pgen_mode_e'(iMODE);
               fnum_n  = frame_cnt_q[PIX_W-1:0];
            end
         end
         HBLK: begin
            if (b_q == BW'(H_BLANK - 1)) begin
               state_n = ACTIVE;
               x_n     = '0;
               b_n     = '0;
            end else begin
               b_n = b_q + 1'b1;
            end
         end
         ACTIVE: begin
            if (x_q == XW'(H_ACTIVE - 1)) begin
               x_n = '0;
               b_n = '0;
               if (y_q == YW'(V_ACTIVE - 1)) begin
                  state_n = VBLK;
                  y_n     = '0;
                  cnt_inc = 1'b1;
               end else begin
                  state_n = HBLK;
                  y_n     = y_q + 1'b1;
               end
            end else begin
               x_n = x_q + 1'b1;
            end
         end
         VBLK: begin
            if (b_q == BW'(V_BLANK - 1)) begin
               b_n = '0;
               // a stop sampled on the last blanking cycle still ends the stream here
               if (stop_q || iSTOP) begin
                  state_n = IDLE;
                  stop_n  = 1'b0;
               end else begin
                  state_n = HBLK;
                  mode_n  = pgen_mode_e'(iMODE);
                  fnum_n  = frame_cnt_q[PIX_W-1:0];
               end
            end else begin
               b_n = b_q + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs are registered from the next-state values so they line up with the state just entered
   d5m_pgen_pixel #(
      .H_ACTIVE (H_ACTIVE)
   ) u_pixel (
      .x         (COORD_W'(x_n)),
      .y         (COORD_W'(y_n)),
      .mode      (mode_n),
      .frame_num (fnum_n),
      .pix       (pix_n)
   );

`ifdef D5M_PGEN_NOISE_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N)
         lfsr_q <= LFSR_SEED;
      else if (state_n == ACTIVE)
         lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   end

   assign noise = {{(PIX_W-2){1'b0}}, lfsr_q[1:0]};
`else
   assign noise = '0;
`endif

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         fval_q <= 1'b0;
         lval_q <= 1'b0;
         busy_q <= 1'b0;
         data_q <= '0;
      end else begin
         fval_q <= (state_n == HBLK) || (state_n == ACTIVE);
         lval_q <= (state_n == ACTIVE);
         busy_q <= (state_n != IDLE);
         data_q <= (state_n == ACTIVE) ? (pix_n ^ noise) : '0;
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N)
         frame_cnt_q <= '0;
      else if (cnt_inc)
         frame_cnt_q <= frame_cnt_q + 32'd1;
   end

   assign oDATA       = data_q;
   assign oFVAL       = fval_q;
   assign oLVAL       = lval_q;
   assign oBUSY       = busy_q;
   assign oFrame_Cont = frame_cnt_q;

endmodule
